// File: rtl/pmu_ctrl_if.sv
// Pin-side bundle of the PMU: serial frame in, pass-through and committed key/power state out.
// master drives the serial frame, slave is the PMU.
interface pmu_ctrl_if #(
  parameter int AES_DATA_WIDTH = 128
);
  logic                        data_i;
  logic                        en;
  logic                        pwr_up_en;
  logic                        tdo;
  logic [2*AES_DATA_WIDTH-1:0] key_o;
  logic                        key_256_o;

  modport master (
    output data_i, en,
    input  pwr_up_en, tdo, key_o, key_256_o
  );

  modport slave (
    input  data_i, en,
    output pwr_up_en, tdo, key_o, key_256_o
  );
endinterface

// File: rtl/pmu_ctrl.sv
// Power management unit: deserialises a header plus AES key frame, commits the key,
// then holds power-up off for the downstream key-expansion latency.
module pmu_ctrl #(
  parameter int HEADER_WIDTH   = 32,
  parameter int AES_DATA_WIDTH = 128,
  parameter int AES_LATENCY    = 10
) (
  input  logic       clk,
  input  logic       rst,
  pmu_ctrl_if.slave  bus
);

  localparam int KEY_W  = 2 * AES_DATA_WIDTH;
  localparam int CNT_W  = $clog2(KEY_W);
  localparam int HIDX_W = $clog2(HEADER_WIDTH);
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAYLOAD, S_EXPAND, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP, CMD_LOAD_128, CMD_LOAD_256, CMD_PWR_DOWN
  } cmd_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HEADER_WIDTH-1:0] hdr_q, hdr_d, hdr_cur;
  logic [KEY_W-1:0]   shadow_q, shadow_d, shadow_cur;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               is256_q, is256_d;
  logic               key256_q, key256_d;
  logic               pwr_q, pwr_d;
  logic               tdo_q, tdo_d;
  logic [CNT_W-1:0]   last_idx;
  cmd_e               cmd;

  // Incoming bit merged into the capture registers, so decode and commit see the final bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hdr_cur                     = hdr_q;
    hdr_cur[cnt_q[HIDX_W-1:0]]  = bus.data_i;
    shadow_cur                  = shadow_q;
    shadow_cur[cnt_q]           = bus.data_i;
    cmd                         = cmd_e'(hdr_cur[1:0]);
    last_idx = is256_q ? CNT_W'(KEY_W - 1) : CNT_W'(AES_DATA_WIDTH - 1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    shadow_d = shadow_q;
    is256_d  = is256_q;
    key_d    = key_q;
    key256_d = key256_q;
    pwr_d    = pwr_q;
    tdo_d    = bus.en & bus.data_i;

    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end

      S_HDR: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else begin
          hdr_d = hdr_cur;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(HEADER_WIDTH - 1)) begin
            cnt_d = '0;
            if (hdr_cur[HEADER_WIDTH-1 -: 8] != MAGIC) begin
              state_d = S_ERR;
            end else begin
              unique case (cmd)
                CMD_NOP: state_d = S_DONE;
                CMD_PWR_DOWN: begin
                  key_d    = '0;
                  key256_d = 1'b0;
                  pwr_d    = 1'b0;
                  state_d  = S_DONE;
                end
                CMD_LOAD_128, CMD_LOAD_256: begin
                  // Clearing here keeps the upper half zero for 128-bit keys and drops any aborted shadow.
                  shadow_d = '0;
                  is256_d  = (cmd == CMD_LOAD_256);
                  state_d  = S_PAYLOAD;
                end
                default: state_d = S_ERR;
              endcase
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (!bus.en) begin
          state_d = S_IDLE;
        end else begin
          shadow_d = shadow_cur;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == last_idx) begin
            key_d    = shadow_cur;
            key256_d = is256_q;
            pwr_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_EXPAND;
          end
        end
      end

      S_EXPAND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(AES_LATENCY - 1)) begin
          pwr_d   = 1'b1;
          cnt_d   = '0;
          state_d = bus.en ? S_DONE : S_IDLE;
        end
      end

      S_DONE, S_ERR: begin
        if (!bus.en) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is256_q  <= 1'b0;
      key_q    <= '0;
      key256_q <= 1'b0;
      pwr_q    <= 1'b0;
      tdo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is256_q  <= is256_d;
      key_q    <= key_d;
      key256_q <= key256_d;
      pwr_q    <= pwr_d;
      tdo_q    <= tdo_d;
    end
  end

  // NOTE: capture registers carry no reset; they are overwritten or cleared before any use.
  always_ff @(posedge clk) begin
    hdr_q    <= hdr_d;
    shadow_q <= shadow_d;
  end

  assign bus.pwr_up_en = pwr_q;
  assign bus.tdo       = tdo_q;
  assign bus.key_o     = key_q;
  assign bus.key_256_o = key256_q;

endmodule

// File: tb/tb_pmu_ctrl.sv
// Randomised frame-level bench for pmu_ctrl: the driver pushes per-edge expectations from a
// frame-level reference model and a negedge monitor pops and compares them.
module tb_pmu_ctrl;
  localparam int HW  = 32;
  localparam int AW  = 128;
  localparam int LAT = 10;
  localparam int KW  = 2 * AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmu_ctrl_if #(.AES_DATA_WIDTH(AW)) bus ();

  pmu_ctrl #(
    .HEADER_WIDTH  (HW),
    .AES_DATA_WIDTH(AW),
    .AES_LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum {K_TDO, K_PWR, K_KEY, K_K256} kind_e;
  typedef struct {
    int          edge_no;
    kind_e       kind;
    logic [KW-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  // Frame-level reference state: what the fabric should currently see.
  logic [KW-1:0] m_key;
  logic          m_k256;
  logic          m_pwr;

  task automatic check(input string name, input int edge_no, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %h expected %h", name, edge_no, act, exp);
    end
  endtask

  task automatic push(input kind_e k, input logic [KW-1:0] v);
    exp_t e;
    e.edge_no = edge_n;
    e.kind    = k;
    e.val     = v;
    sb_q.push_back(e);
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [KW-1:0] rkey();
    logic [KW-1:0] r;
    for (int i = 0; i < KW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock edge of stimulus; the caller updates the model beforehand if this edge changes it.
  task automatic step(input logic r, input logic e, input logic d);
    rst        = r;
    bus.en     = e;
    bus.data_i = d;
    @(posedge clk);
    #1;
    edge_n++;
    push(K_TDO,  KW'((!r && e) ? d : 1'b0));
    push(K_PWR,  KW'(m_pwr));
    push(K_KEY,  m_key);
    push(K_K256, KW'(m_k256));
  endtask

  task automatic frame(input logic [7:0] magic, input logic [1:0] cmd, input logic [KW-1:0] key,
                       input int nbits, input int extra, input int rst_at);
    logic [HW-1:0] hdr;
    int  n;
    bit  valid;
    bit  load;
    hdr   = {magic, 22'($urandom), cmd};
    valid = (magic == 8'hA5);
    load  = valid && (cmd == 2'b01 || cmd == 2'b10);
    n     = (cmd == 2'b10) ? KW : AW;

    step(1'b0, 1'b1, rbit());
    for (int k = 0; k < HW; k++) begin
      if (k == HW - 1 && valid && cmd == 2'b11) begin
        m_key  = '0;
        m_k256 = 1'b0;
        m_pwr  = 1'b0;
      end
      step(1'b0, 1'b1, hdr[k]);
    end

    if (!load) begin
      for (int i = 0; i < nbits; i++) step(1'b0, 1'b1, rbit());
    end else begin
      for (int k = 0; k < n && k < nbits; k++) begin
        if (k == n - 1) begin
          m_key  = (n == KW) ? key : {{AW{1'b0}}, key[AW-1:0]};
          m_k256 = (n == KW);
          m_pwr  = 1'b0;
        end
        step(1'b0, 1'b1, key[k]);
      end
      if (nbits < n) begin
        step(1'b0, 1'b0, rbit());
        return;
      end
      for (int i = 0; i < LAT; i++) begin
        if (i == rst_at) begin
          m_key  = '0;
          m_k256 = 1'b0;
          m_pwr  = 1'b0;
          step(1'b1, 1'b1, rbit());
          step(1'b0, 1'b0, rbit());
          return;
        end
        if (i == LAT - 1) m_pwr = 1'b1;
        step(1'b0, 1'b1, rbit());
      end
    end

    for (int i = 0; i < extra; i++) step(1'b0, 1'b1, rbit());
    step(1'b0, 1'b0, rbit());
  endtask

  // Monitor: compare every expectation due at the current edge.
  initial begin
    exp_t  x;
    logic [KW-1:0] act;
    string name;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_n) begin
        x = sb_q.pop_front();
        act  = '0;
        name = "";
        case (x.kind)
          K_TDO:  begin act = KW'(bus.tdo);       name = "tdo";       end
          K_PWR:  begin act = KW'(bus.pwr_up_en); name = "pwr_up_en"; end
          K_KEY:  begin act = bus.key_o;          name = "key_o";     end
          K_K256: begin act = KW'(bus.key_256_o); name = "key_256_o"; end
          default: ;
        endcase
        if (x.edge_no != edge_n) name = {name, "_stale"};
        check(name, x.edge_no, act, x.val);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] magic;
    m_key      = '0;
    m_k256     = 1'b0;
    m_pwr      = 1'b0;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.data_i = 1'b0;

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    frame(8'hA5, 2'b10, rkey(), KW, 1, -1);
    frame(8'hA5, 2'b01, rkey(), AW, 3, -1);
    frame(8'h5A, 2'b10, rkey(), KW, 0, -1);
    frame(8'hA5, 2'b10, rkey(), KW, 2, -1);
    frame(8'hA5, 2'b10, rkey(), 100, 0, -1);
    step(1'b0, 1'b0, 1'b1);
    frame(8'hA5, 2'b01, rkey(), AW, 0, -1);
    frame(8'hA5, 2'b11, rkey(), 20, 2, -1);
    frame(8'hA5, 2'b10, rkey(), KW, 0, -1);
    frame(8'hA5, 2'b01, rkey(), AW, 0, 5);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    frame(8'hA5, 2'b00, rkey(), 5, 0, -1);

    for (int f = 0; f < 8; f++) begin
      magic = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA5;
      frame(magic, 2'($urandom), rkey(),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, KW - 1)) : KW,
            int'($urandom_range(0, 4)), -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'b0, rbit());
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", edge_n, KW'(sb_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmu_ctrl.md
# pmu_ctrl

Power management unit for the secured-bitstream path. It receives a serial command frame on a 1-bit interface: a framing cycle, a 32-bit header, then a 128- or 256-bit AES key. It waits a fixed AES key-expansion latency before asserting `pwr_up_en` to the fabric. The unit sits between the external configuration pin interface and the AES decryption core, which consumes `key_o`.

## Interface
- `HEADER_WIDTH`, 32: header length in bits.
- `AES_DATA_WIDTH`, 128: AES block/base key width; payload is 1× or 2× this value.
- `AES_LATENCY`, 10: cycles reserved for downstream key expansion before power-up.

- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `data_i` in 1: serial data, LSB first.
- `en` in 1: frame enable; the rising edge starts a frame, and a low level ends or aborts it.
- `pwr_up_en` out 1: fabric power-up enable.
- `tdo` out 1: serial pass-through for daisy-chaining.
- `key_o` out 2*AES_DATA_WIDTH: committed key, zero-extended when 128-bit.
- `key_256_o` out 1: 1 = committed key is 256-bit.

## Operation
- Header layout after capture: [1:0] cmd, [23:2] reserved (ignored), [31:24] magic = 8'hA5.
- Commands: 2'b00 NOP, 2'b01 LOAD_KEY_128, 2'b10 LOAD_KEY_256, 2'b11 PWR_DOWN.
- Header bit k is the k-th `data_i` sample after the framing cycle. Payload bit k is stored at shadow[k], LSB first.
- States and transitions:
  - IDLE: `en`=1 → HDR. This cycle is the framing cycle; `data_i` is ignored and the bit counter is cleared.
  - HDR: store `data_i` at hdr[cnt]. On cnt = HEADER_WIDTH-1, decode the header value including the current bit:
    - magic mismatch → ERR;
    - NOP → DONE;
    - PWR_DOWN → clear `key_o` and `key_256_o`, drop `pwr_up_en`, go to DONE;
    - LOAD_* → PAYLOAD with length 128 or 256; counter cleared.
  - PAYLOAD: shadow[cnt] ← `data_i`. On the last bit, go to EXPAND and in the same edge:
    - `key_o` ← shadow, including the final bit;
    - `key_256_o` set per command;
    - `pwr_up_en` ← 0;
    - counter cleared.
  - EXPAND: count AES_LATENCY cycles, ignoring `en` and `data_i`. Then set `pwr_up_en` ← 1 and go to DONE if `en`=1, otherwise IDLE.
  - DONE and ERR: ignore `data_i`; `en`=0 → IDLE. Extra bits after the payload are ignored.
- Abort: `en`=0 while in HDR or PAYLOAD → IDLE. Nothing is committed; `key_o`, `key_256_o` and `pwr_up_en` keep their values; the shadow is discarded.
- A 128-bit load clears shadow[255:128] so `key_o` upper half is 0.
- `tdo` ← `data_i` registered when `en`=1, else 0.
- `rst` overrides everything, from any state.

## Timing
- Reset values: state IDLE, `pwr_up_en`=0, `tdo`=0, `key_o`=0, `key_256_o`=0, counters 0.
- Frame edge numbering: edge 0 samples `en`=1 (framing cycle). Edges 1..32 sample the header. Edges 33..32+N sample the payload, N = 128 or 256.
- `key_o` is valid after edge 32+N.
- `pwr_up_en` goes 1 after edge 32+N+AES_LATENCY. For N=256 with default parameters this is edge 298.
- `tdo` lags `data_i` by exactly 1 cycle.
- A new frame requires `en` low for ≥1 cycle; `en` held high never restarts a frame.
- `rst` asserted mid-EXPAND: `pwr_up_en` stays 0 and `key_o` is cleared.

## Test plan
- 256-bit load: `rst` 2 cycles; `en`=1; framing bit; header {8'hA5, 22'h0, 2'b10}; 256 key bits LSB first; 1 extra bit → `key_o` = key, `key_256_o`=1, `pwr_up_en` rises exactly 10 cycles after the last key bit, stays 1 after `en` drops.
- 128-bit load with header cmd 2'b01 → `key_o[127:0]` = key, `key_o[255:128]`=0, `key_256_o`=0, `pwr_up_en` rises 10 cycles after bit 160.
- Bad magic 8'h5A with 256 trailing bits → state ERR, `key_o` and `pwr_up_en` unchanged; next valid frame succeeds.
- Abort: drop `en` after 100 payload bits of a 256-bit load → no commit, `pwr_up_en` unchanged; a subsequent full frame commits correctly.
- PWR_DOWN after a successful load → `pwr_up_en`=0, `key_o`=0 after header bit 32.
- `tdo` equals `data_i` delayed 1 cycle while `en`=1, and is 0 while `en`=0. `rst` during EXPAND leaves `pwr_up_en`=0 and `key_o`=0.
